fpu_issue: RTL and testbench
============================

# fpu_issue

In-order issue stage directly upstream of the FPU execution units: the single-cycle sign/zero test unit, fadd, fmul and fdiv. Accepts one decoded FPU instruction per cycle over a valid/ready handshake and registers the operands to the selected unit with a one-cycle start pulse. A writeback-slot reservation scoreboard ensures that no two units complete in the same cycle, so the shared FP writeback port never sees a collision. The block emits an aligned writeback tag stream (valid, class, rd) that the writeback mux uses to select unit results.

## Interface
- LAT_CMP, 1, cycles from unit start to registered result, compare/sign class
- LAT_ADD, 3, fadd latency (pipelined)
- LAT_MUL, 2, fmul latency (pipelined)
- LAT_DIV, 8, fdiv latency (unpipelined)
- RD_W, 6, destination register tag width
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when high with in_valid
- in_class  in  2  0=CMP 1=ADD 2=MUL 3=DIV
- in_fn  in  3  function within class, passed through unchanged
- in_rd  in  RD_W  destination tag
- in_op1, in_op2  in  32  IEEE-754 single operands
- iss_start  out  4  one-hot unit start pulse, bit index = class
- iss_fn  out  3  registered function
- iss_op1, iss_op2  out  32  registered operands
- wb_valid  out  1  a unit result is present this cycle
- wb_class  out  2  class of the completing unit
- wb_rd  out  RD_W  destination of the completing result

## Operation
- Latency lookup: LAT(c) selects LAT_CMP/ADD/MUL/DIV. All latencies are at least 1 and at most MAXLAT = max of the four.
- Reservation register: slot[1..MAXLAT]. Each entry holds {v, class, rd}. Every cycle, slot[k] <= slot[k+1] and slot[MAXLAT] is cleared. The wb_* outputs are registered from slot[1].
- Accept condition: in_ready = ~slot[LAT(in_class)+1].v (the slot position after the shift) & ~(in_class==DIV & div_busy). For LAT(in_class)==MAXLAT, the slot term is always free. in_ready depends combinationally on in_class; it never depends on in_valid.
- On accept, in the same edge as the shift:
  - slot[LAT] <= {1, in_class, in_rd};
  - iss_start <= onehot(in_class); iss_fn/op1/op2 <= inputs.
- With no accept, iss_start <= 0; iss_fn/op operands hold their previous values.
- div_busy: a counter loaded with LAT_DIV on a DIV accept and decremented to 0. A DIV is accepted only when div_busy is 0. Back-to-back CMP/ADD/MUL are unrestricted except for slot conflicts.
- Ordering: strictly in order. A refused instruction blocks all younger instructions. Results may complete out of order, with tags correct.
- Reset: iss_start=0, wb_valid=0, wb_class=0, wb_rd=0, iss_fn=0, iss_op1/op2=0, all slots invalid, div_busy=0. Reset mid-operation discards every in-flight tag. The units share this reset, so no stale result appears.

## Timing
- Accept at edge T: iss_start is high during cycle T+1 (one cycle only), and the unit samples at edge T+1.
- wb_valid, wb_class and wb_rd are high during cycle T+1+LAT(class), coinciding with the unit's registered result.
- CMP example: accept at edge 0, iss_start[0] in cycle 1, wb_valid in cycle 2.
- Conflict: an ADD accepted at T reserves wb cycle T+4. A MUL at T+1 also targets T+4, so in_ready=0 at T+1. The same MUL is accepted at T+2 and writes back at T+5.
- Throughput: 1 instruction/cycle when there are no conflicts. DIV: at most 1 per LAT_DIV cycles.
- Simultaneous shift-out of slot[1] and write into any slot in the same edge is legal. The write always targets a post-shift position.

## Structure
- Shared package fpu_pkg holds:
  - class encodings CLS_CMP/ADD/MUL/DIV;
  - fn encodings (e.g. CMP fn 0 = isneg, 1 = iszero);
  - default latency constants;
  - slot entry layout.
- Sub-module wb_slot_sched holds the reservation shift register, the free-slot query and the wb_* outputs. fpu_issue keeps the handshake, operand registers, start decode and div_busy.

## Test plan
- After reset, a CMP with op1=0xBF800000 at edge 0 -> iss_start=4'b0001 in cycle 1 with iss_op1=0xBF800000; wb_valid=1, wb_class=0, wb_rd=in_rd in cycle 2. All outputs are 0 during reset.
- ADD at T, then MUL offered at T+1 -> in_ready=0 at T+1, MUL accepted at T+2, wb for ADD at T+4 and for MUL at T+5. wb_valid is never high for two tags in one cycle.
- DIV accepted, second DIV offered immediately -> held for 8 cycles, accepted when div_busy reaches 0. A CMP interleaved meanwhile still issues, and the blocked DIV stalls younger instructions.
- Stream of 16 back-to-back CMPs -> in_ready constantly 1, wb_valid high for 16 consecutive cycles, with rd order preserved.
- Reset asserted with an ADD and a DIV in flight -> next cycle wb_valid=0 and iss_start=0, no later wb for those tags, and in_ready=1 for any class.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings for the FPU issue slice.
// Unit classes, function codes, default latencies, slot layout.
package fpu_pkg;

  typedef enum logic [1:0] {
    CLS_CMP = 2'd0,
    CLS_ADD = 2'd1,
    CLS_MUL = 2'd2,
    CLS_DIV = 2'd3
  } fpu_cls_e;

  localparam logic [2:0] FN_CMP_ISNEG  = 3'd0;
  localparam logic [2:0] FN_CMP_ISZERO = 3'd1;
  localparam logic [2:0] FN_ADD_ADD    = 3'd0;
  localparam logic [2:0] FN_ADD_SUB    = 3'd1;

  localparam int LAT_CMP_D = 1;
  localparam int LAT_ADD_D = 3;
  localparam int LAT_MUL_D = 2;
  localparam int LAT_DIV_D = 8;

  localparam int RD_W = 6;

  typedef struct packed {
    logic            v;
    fpu_cls_e        cls;
    logic [RD_W-1:0] rd;
  } slot_t;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/wb_slot_sched.sv
// wb_slot_sched: writeback-slot reservation shift register.
// slot[k] completes k+1 cycles from now; wb_* registered from slot[1].
module wb_slot_sched
  import fpu_pkg::*;
#(
  parameter int MAXLAT = 8,
  parameter int LW     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [LW-1:0]   i_qlat,
  output logic            o_free,
  input  logic            i_wr,
  input  logic [LW-1:0]   i_wlat,
  input  slot_t           i_went,
  output logic            o_wb_valid,
  output logic [1:0]      o_wb_class,
  output logic [RD_W-1:0] o_wb_rd
);

  slot_t r_slot [1:MAXLAT];
  slot_t w_nxt  [1:MAXLAT];
  slot_t r_wb;
  logic  w_free;

  // free query: the slot that lands at position qlat after this shift
  always_comb begin
    w_free = 1'b1;
    for (int k = 1; k < MAXLAT; k++) begin
      if (i_qlat == LW'(k) && r_slot[k+1].v)
        w_free = 1'b0;
    end
  end

  // next slot image: shift down by one, then drop in the new reservation
  always_comb begin
    for (int k = 1; k < MAXLAT; k++)
      w_nxt[k] = r_slot[k+1];
    w_nxt[MAXLAT] = '0;
    for (int k = 1; k <= MAXLAT; k++) begin
      if (i_wr && i_wlat == LW'(k))
        w_nxt[k] = i_went;
    end
  end

  // slot register and writeback tag register
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= MAXLAT; k++)
        r_slot[k] <= '0;
      r_wb <= '0;
    end else begin
      for (int k = 1; k <= MAXLAT; k++)
        r_slot[k] <= w_nxt[k];
      r_wb <= r_slot[1];
    end
  end

  assign o_free     = w_free;
  assign o_wb_valid = r_wb.v;
  assign o_wb_class = r_wb.cls;
  assign o_wb_rd    = r_wb.rd;

endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: in-order issue into CMP/ADD/MUL/DIV units.
// Reserves a unique writeback cycle per instruction.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int LAT_CMP = LAT_CMP_D,
  parameter int LAT_ADD = LAT_ADD_D,
  parameter int LAT_MUL = LAT_MUL_D,
  parameter int LAT_DIV = LAT_DIV_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_class,
  input  logic [2:0]      in_fn,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_op1,
  input  logic [31:0]     in_op2,
  output logic [3:0]      iss_start,
  output logic [2:0]      iss_fn,
  output logic [31:0]     iss_op1,
  output logic [31:0]     iss_op2,
  output logic            wb_valid,
  output logic [1:0]      wb_class,
  output logic [RD_W-1:0] wb_rd
);

  localparam int MAXLAT =
    max4(LAT_CMP, LAT_ADD, LAT_MUL, LAT_DIV);
  localparam int LW = $clog2(MAXLAT + 1);
  localparam int DW = $clog2(LAT_DIV + 1);

  logic [LW-1:0] w_lat;
  logic [3:0]    w_onehot;
  logic          w_free;
  logic          w_is_div;
  logic          w_div_ok;
  logic          w_acc;
  slot_t         w_ent;

  logic [3:0]    r_start;
  logic [2:0]    r_fn;
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;
  logic [DW-1:0] r_div_busy;

  // latency and start-line decode for the offered class
  always_comb begin
    w_lat    = LW'(LAT_CMP);
    w_onehot = 4'b0001;
    unique case (1'b1)
      (in_class == CLS_CMP): begin
        w_lat    = LW'(LAT_CMP);
        w_onehot = 4'b0001;
      end
      (in_class == CLS_ADD): begin
        w_lat    = LW'(LAT_ADD);
        w_onehot = 4'b0010;
      end
      (in_class == CLS_MUL): begin
        w_lat    = LW'(LAT_MUL);
        w_onehot = 4'b0100;
      end
      (in_class == CLS_DIV): begin
        w_lat    = LW'(LAT_DIV);
        w_onehot = 4'b1000;
      end
    endcase
  end

  assign w_is_div = (in_class == CLS_DIV);
  assign w_div_ok = (r_div_busy == '0);
  assign in_ready = w_free & ~(w_is_div & ~w_div_ok);
  assign w_acc    = in_valid & in_ready;

  assign w_ent = '{
    v:   1'b1,
    cls: fpu_cls_e'(in_class),
    rd:  in_rd
  };

  wb_slot_sched #(
    .MAXLAT (MAXLAT),
    .LW     (LW)
  ) u_sched (
    .clk        (clk),
    .reset      (reset),
    .i_qlat     (w_lat),
    .o_free     (w_free),
    .i_wr       (w_acc),
    .i_wlat     (w_lat),
    .i_went     (w_ent),
    .o_wb_valid (wb_valid),
    .o_wb_class (wb_class),
    .o_wb_rd    (wb_rd)
  );

  // start pulse and operand capture on accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start <= '0;
      r_fn    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
    end else if (w_acc) begin
      r_start <= w_onehot;
      r_fn    <= in_fn;
      r_op1   <= in_op1;
      r_op2   <= in_op2;
    end else begin
      r_start <= '0;
    end
  end

  // divider occupancy countdown; fdiv is not pipelined
  always_ff @(posedge clk) begin
    if (!reset)
      r_div_busy <= '0;
    else if (w_acc && w_is_div)
      r_div_busy <= DW'(LAT_DIV);
    else if (!w_div_ok)
      r_div_busy <= r_div_busy - DW'(1);
  end

  assign iss_start = r_start;
  assign iss_fn    = r_fn;
  assign iss_op1   = r_op1;
  assign iss_op2   = r_op2;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: scoreboard bench for fpu_issue.
// Model tracks reserved writeback cycles and divider availability.
module tb_fpu_issue;

  localparam int LDIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_class = 2'd0;
  logic [2:0]  in_fn = 3'd0;
  logic [5:0]  in_rd = 6'd0;
  logic [31:0] in_op1 = 32'd0;
  logic [31:0] in_op2 = 32'd0;
  logic [3:0]  iss_start;
  logic [2:0]  iss_fn;
  logic [31:0] iss_op1;
  logic [31:0] iss_op2;
  logic        wb_valid;
  logic [1:0]  wb_class;
  logic [5:0]  wb_rd;

  fpu_issue dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_fn     (in_fn),
    .in_rd     (in_rd),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .iss_start (iss_start),
    .iss_fn    (iss_fn),
    .iss_op1   (iss_op1),
    .iss_op2   (iss_op2),
    .wb_valid  (wb_valid),
    .wb_class  (wb_class),
    .wb_rd     (wb_rd)
  );

  always #10 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [1:0] cls;
    logic [5:0] rd;
  } wbx_t;

  typedef struct {
    int          cyc;
    logic [3:0]  st;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } isx_t;

  wbx_t wbq[$];
  isx_t isq[$];
  bit   res[int];
  int   div_ok = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, edge_n);
    end
  endtask

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'd0:    return 1;
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 8;
    endcase
  endfunction

  // ready if the target writeback cycle is unclaimed and fdiv is free
  function automatic bit exp_ready(input logic [1:0] c, input int e);
    if (res.exists(e + 1 + lat_of(c))) return 1'b0;
    if (c == 2'd3 && e < div_ok) return 1'b0;
    return 1'b1;
  endfunction

  task automatic record(input logic [1:0] c, input logic [2:0] f,
                        input logic [5:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int e);
    int   w;
    int   i;
    wbx_t x;
    isx_t s;
    w = e + 1 + lat_of(c);
    res[w] = 1'b1;
    if (c == 2'd3) div_ok = e + LDIV + 1;
    s.cyc = e + 1;
    s.st = 4'b0001 << c;
    s.fn = f;
    s.a = a;
    s.b = b;
    isq.push_back(s);
    x.cyc = w;
    x.cls = c;
    x.rd = rd;
    i = 0;
    while (i < wbq.size() && wbq[i].cyc < w) i++;
    wbq.insert(i, x);
  endtask

  task automatic offer(input logic [1:0] c, input logic [2:0] f,
                       input logic [5:0] rd, input logic [31:0] a,
                       input logic [31:0] b, output int waits);
    bit ex;
    waits = 0;
    forever begin
      @(negedge clk);
      #2;
      in_valid = 1'b1;
      in_class = c;
      in_fn = f;
      in_rd = rd;
      in_op1 = a;
      in_op2 = b;
      #1;
      ex = exp_ready(c, edge_n);
      chk("in_ready", {63'd0, in_ready}, {63'd0, ex});
      if (in_ready) begin
        record(c, f, rd, a, b, edge_n);
        break;
      end
      waits++;
      if (waits > 40) begin
        checks++;
        failures++;
        $display("FAIL offer_timeout: class %0d never accepted", c);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  // monitor: compares DUT outputs against the expected queues
  always @(negedge clk) begin
    wbx_t x;
    isx_t s;
    if (mon_en) begin
      while (wbq.size() > 0 && wbq[0].cyc < edge_n) begin
        x = wbq.pop_front();
        checks++;
        failures++;
        $display("FAIL wb_missing: rd %0d due cycle %0d", x.rd, x.cyc);
      end
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got rd %0d class %0d",
                   wb_rd, wb_class);
        end else begin
          x = wbq.pop_front();
          chk("wb_cycle", 64'(edge_n), 64'(x.cyc));
          chk("wb_class", {62'd0, wb_class}, {62'd0, x.cls});
          chk("wb_rd", {58'd0, wb_rd}, {58'd0, x.rd});
        end
      end
      while (isq.size() > 0 && isq[0].cyc < edge_n) begin
        s = isq.pop_front();
        checks++;
        failures++;
        $display("FAIL iss_missing: due cycle %0d", s.cyc);
      end
      if (iss_start != 4'd0) begin
        if (isq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL iss_unexpected: got start %b", iss_start);
        end else begin
          s = isq.pop_front();
          chk("iss_cycle", 64'(edge_n), 64'(s.cyc));
          chk("iss_start", {60'd0, iss_start}, {60'd0, s.st});
          chk("iss_fn", {61'd0, iss_fn}, {61'd0, s.fn});
          chk("iss_op1", {32'd0, iss_op1}, {32'd0, s.a});
          chk("iss_op2", {32'd0, iss_op2}, {32'd0, s.b});
        end
      end
    end
  end

  initial begin
    int w;
    int sum;
    logic [1:0] c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iss_start", {60'd0, iss_start}, 64'd0);
    chk("rst_iss_fn", {61'd0, iss_fn}, 64'd0);
    chk("rst_iss_op1", {32'd0, iss_op1}, 64'd0);
    chk("rst_iss_op2", {32'd0, iss_op2}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_class", {62'd0, wb_class}, 64'd0);
    chk("rst_wb_rd", {58'd0, wb_rd}, 64'd0);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;

    offer(2'd0, 3'd0, 6'd5, 32'hBF80_0000, 32'h0, w);
    chk("cmp_wait", 64'(w), 64'd0);
    idle(4);

    offer(2'd1, 3'd0, 6'd10, 32'h3F80_0000, 32'h4000_0000, w);
    offer(2'd2, 3'd0, 6'd11, 32'h4040_0000, 32'h4080_0000, w);
    chk("mul_stall", 64'(w), 64'd1);
    idle(6);

    offer(2'd3, 3'd0, 6'd20, 32'h4120_0000, 32'h4000_0000, w);
    offer(2'd3, 3'd0, 6'd21, 32'h4130_0000, 32'h4040_0000, w);
    chk("div_hold", 64'(w), 64'd8);
    offer(2'd0, 3'd1, 6'd23, 32'h0, 32'h0, w);
    chk("cmp_mid_div", 64'(w), 64'd0);
    offer(2'd3, 3'd0, 6'd24, 32'h4140_0000, 32'h4080_0000, w);
    chk("div_after_cmp", 64'(w), 64'd7);
    offer(2'd0, 3'd0, 6'd25, 32'h8000_0000, 32'h0, w);
    idle(12);

    sum = 0;
    for (int i = 0; i < 16; i++) begin
      offer(2'd0, 3'(i % 2), 6'(32 + i), $urandom, $urandom, w);
      sum += w;
    end
    chk("cmp_stream_waits", 64'(sum), 64'd0);
    idle(4);

    offer(2'd1, 3'd1, 6'd40, 32'h1, 32'h2, w);
    offer(2'd3, 3'd0, 6'd41, 32'h3, 32'h4, w);
    @(negedge clk);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    wbq.delete();
    isq.delete();
    res.delete();
    div_ok = 0;
    @(negedge clk);
    chk("rst_mid_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_mid_iss_start", {60'd0, iss_start}, 64'd0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_class = 2'(k);
      #1;
      chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    end
    idle(12);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 2));
      end else begin
        c = 2'($urandom_range(0, 3));
        offer(c, 3'($urandom_range(0, 7)), 6'($urandom),
              $urandom, $urandom, w);
      end
    end
    idle(15);
    chk("wbq_drained", 64'(wbq.size()), 64'd0);
    chk("isq_drained", 64'(isq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
